// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Port m0 is the core load/store port, m1 the debug/DMA port. Grants are
// combinational; read data returns one cycle after the grant.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration.
// Without it, fixed priority (m0 over m1) with starvation relief for m1.
module dmem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  logic  gnt0;
  logic  gnt1;
  logic  rd_pend_q;
  logic  rd_pend_d;
  port_e rd_sel_q;
  port_e rd_sel_d;

`ifdef DMEM_ARB_RR_EN
  port_e last_gnt_q;
  port_e last_gnt_d;

  // Round-robin grant: on contention the port not granted last time wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (last_gnt_q == PORT_M1) gnt0 = 1'b1;
        else                       gnt1 = 1'b1;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  // Remember the most recently granted port; hold when idle
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0)      last_gnt_d = PORT_M0;
    else if (gnt1) last_gnt_d = PORT_M1;
  end

  // Reset to m1 so that m0 wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_gnt_q <= PORT_M1;
    else       last_gnt_q <= last_gnt_d;
  end
`else
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starved;

  assign starved = (starve_cnt_q == STARVE_LIM);

  // Fixed priority m0 over m1, overridden once m1 has waited STARVE_MAX cycles
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m1_req && (!m0_req || starved)) gnt1 = 1'b1;
      else                                gnt0 = m0_req;
    end
  end

  // Count consecutive denied m1 cycles; clear on grant or dropped request
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req || gnt1)  starve_cnt_d = '0;
    else if (!starved)    starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Memory request mux and read-tracking next state from the granted port
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_pend_d = 1'b0;
    rd_sel_d  = rd_sel_q;
    if (gnt0) begin
      mem_wr    = m0_we;
      mem_rd    = !m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      rd_pend_d = !m0_we;
      if (!m0_we) rd_sel_d = PORT_M0;
    end else if (gnt1) begin
      mem_wr    = m1_we;
      mem_rd    = !m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      rd_pend_d = !m1_we;
      if (!m1_we) rd_sel_d = PORT_M1;
    end
  end

  // Pending-read tracking: one outstanding read per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_sel_q  <= PORT_M0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  // Route returning read data to the port that issued the read; zero elsewhere
  always_comb begin
    m0_rvalid = rd_pend_q && (rd_sel_q == PORT_M0) && !reset;
    m1_rvalid = rd_pend_q && (rd_sel_q == PORT_M1) && !reset;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and
// read returns (tagged with cycle number); a negedge monitor pops and checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [8:0]  m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [8:0]  m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr, mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous read, one-cycle latency
  logic [31:0] tb_mem [512];
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? tb_mem[mem_addr] : 32'h0BAD_F00D;
  end

  typedef struct { int cyc; logic port; logic we; logic [8:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct { int cyc; logic port; logic [31:0] data; } rv_t;
  gnt_t gq[$];
  rv_t  rq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: got event-state mismatch expected scoreboard entry", name, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    gnt_t g;
    rv_t  r;
    if (reset) begin
      chk("rst_gnt",    {m0_gnt, m1_gnt}, '0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, '0);
      chk("rst_strobe", {mem_wr, mem_rd}, '0);
      chk("rst_rdata",  {m0_rdata, m1_rdata}, '0);
    end else begin
      chk("gnt_onehot", m0_gnt & m1_gnt, '0);
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        flag("gnt_missing");
        void'(gq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        flag("rvalid_missing");
        void'(rq.pop_front());
      end
      if (m0_gnt || m1_gnt) begin
        if (gq.size() == 0 || gq[0].cyc != cyc) flag("gnt_unexpected");
        else begin
          g = gq.pop_front();
          chk("gnt_port", m1_gnt, g.port);
          chk("mem_wr", mem_wr, g.we);
          chk("mem_rd", mem_rd, !g.we);
          chk("mem_addr", mem_addr, g.addr);
          if (g.we) chk("mem_wdata", mem_wdata, g.wdata);
        end
      end else begin
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          flag("gnt_missing");
          void'(gq.pop_front());
        end
        chk("idle_mem", {mem_wr, mem_rd, mem_addr, mem_wdata}, '0);
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0 || rq[0].cyc != cyc) flag("rvalid_unexpected");
        else begin
          r = rq.pop_front();
          chk("rvalid_port", {m0_rvalid, m1_rvalid}, r.port ? 2'b01 : 2'b10);
          chk("rdata", r.port ? m1_rdata : m0_rdata, r.data);
        end
      end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
        flag("rvalid_missing");
        void'(rq.pop_front());
      end
      if (!m0_rvalid) chk("m0_rdata_idle", m0_rdata, '0);
      if (!m1_rvalid) chk("m1_rdata_idle", m1_rdata, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic req, input logic we, input logic [8:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic [8:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic exp_gnt(input logic port, input logic we, input logic [8:0] a, input logic [31:0] d);
    gq.push_back('{cyc, port, we, a, d});
  endtask

  task automatic exp_rv(input logic port, input logic [31:0] data);
    rq.push_back('{cyc + 1, port, data});
  endtask

  // Reset pulse of two cycles with a live m0 read request held on the inputs
  task automatic do_reset();
    reset = 1'b1;
    set0(1'b1, 1'b0, 9'h010, '0);
    set1(1'b1, 1'b0, 9'h002, '0);
    step();
    step();
    reset = 1'b0;
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
  endtask

  // One cycle of contention: m0 reads 0x005, m1 reads 0x006 when m1_on
  task automatic both_cycle(input logic m1_on, input logic exp_port);
    set0(1'b1, 1'b0, 9'h005, '0);
    set1(m1_on, 1'b0, 9'h006, '0);
    if (exp_port) begin
      exp_gnt(1'b1, 1'b0, 9'h006, '0);
      exp_rv(1'b1, 32'h2222_0006);
    end else begin
      exp_gnt(1'b0, 1'b0, 9'h005, '0);
      exp_rv(1'b0, 32'h1111_0005);
    end
    step();
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] m1on;
    logic [7:0] win;
    for (int i = 0; i < 512; i++) tb_mem[i] = '0;
    tb_mem[9'h010] = 32'hDEAD_BEEF;
    tb_mem[9'h002] = 32'hCAFE_0002;
    tb_mem[9'h003] = 32'hA5A5_0003;
    tb_mem[9'h004] = 32'h5A5A_0004;
    tb_mem[9'h005] = 32'h1111_0005;
    tb_mem[9'h006] = 32'h2222_0006;

    #1;
    do_reset();
    step();

    // Single m0 read
    set0(1'b1, 1'b0, 9'h010, '0);
    exp_gnt(1'b0, 1'b0, 9'h010, '0);
    exp_rv(1'b0, 32'hDEAD_BEEF);
    step();
    set0(1'b0, 1'b0, '0, '0);
    step();

    // m0 write vs m1 read in the same cycle
    do_reset();
    set0(1'b1, 1'b1, 9'h1FF, 32'h1234_5678);
    set1(1'b1, 1'b0, 9'h002, '0);
    exp_gnt(1'b0, 1'b1, 9'h1FF, 32'h1234_5678);
    step();
    set0(1'b0, 1'b0, '0, '0);
    exp_gnt(1'b1, 1'b0, 9'h002, '0);
    exp_rv(1'b1, 32'hCAFE_0002);
    step();
    set1(1'b0, 1'b0, '0, '0);
    step();

    // Back-to-back reads, different ports, then same port
    set0(1'b1, 1'b0, 9'h003, '0);
    exp_gnt(1'b0, 1'b0, 9'h003, '0);
    exp_rv(1'b0, 32'hA5A5_0003);
    step();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b1, 1'b0, 9'h004, '0);
    exp_gnt(1'b1, 1'b0, 9'h004, '0);
    exp_rv(1'b1, 32'h5A5A_0004);
    step();
    set1(1'b1, 1'b0, 9'h1FF, '0);
    exp_gnt(1'b1, 1'b0, 9'h1FF, '0);
    exp_rv(1'b1, 32'h1234_5678);
    step();
    set1(1'b0, 1'b0, '0, '0);
    step();

    // Cancelled request: m1 loses once, then withdraws without access
    do_reset();
    set0(1'b1, 1'b1, 9'h020, 32'h0000_0020);
    set1(1'b1, 1'b0, 9'h030, '0);
    exp_gnt(1'b0, 1'b1, 9'h020, 32'h0000_0020);
    step();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    step();
    step();

    // Continuous contention after reset
    do_reset();
`ifdef DMEM_ARB_RR_EN
    pat = 10'b10_1010_1010;
`else
    pat = 10'b10_0001_0000;
`endif
    for (int i = 0; i < 10; i++) both_cycle(1'b1, pat[i]);
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    step();

`ifndef DMEM_ARB_RR_EN
    // Starvation counter clears when m1 drops its request
    do_reset();
    m1on = 8'b1111_1011;
    win  = 8'b1000_0000;
    for (int i = 0; i < 8; i++) both_cycle(m1on[i], win[i]);
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    step();
`endif

    // Reset in the cycle after a read grant suppresses the rvalid
    step();
    set0(1'b1, 1'b0, 9'h003, '0);
    exp_gnt(1'b0, 1'b0, 9'h003, '0);
    step();
    set0(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    set0(1'b1, 1'b0, 9'h010, '0);
    exp_gnt(1'b0, 1'b0, 9'h010, '0);
    exp_rv(1'b0, 32'hDEAD_BEEF);
    step();
    set0(1'b0, 1'b0, '0, '0);
    step();
    step();

    chk("gnt_queue_drained", 64'(gq.size()), '0);
    chk("rvalid_queue_drained", 64'(rq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
